// File: rtl/ram_arb_pkg.sv
// Shared sizing and requester index constants for the parameter/key RAM arbiter.
// Receiver, AES and transmitter blocks use the same REQ_* indices.
package ram_arb_pkg;
    localparam int N_REQ     = 3;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    localparam int REQ_RX  = 0;
    localparam int REQ_AES = 1;
    localparam int REQ_TX  = 2;
endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first asserted req scanning upward from ptr, modulo N.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);
    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between RX, AES and TX, with
// optional bounded burst lock and a one-hot owner pipeline for read returns.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ     = ram_arb_pkg::N_REQ,
    parameter int ADDR_W    = ram_arb_pkg::ADDR_W,
    parameter int DATA_W    = ram_arb_pkg::DATA_W,
    parameter int MAX_BURST = ram_arb_pkg::MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    input  logic                     pause,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [CNT_W-1:0]            burst_cnt_q, burst_cnt_d;
    logic                        ram_en_q, ram_en_d;
    logic                        ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]           ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]           ram_wdata_q, ram_wdata_d;
    logic [1:0][N_REQ-1:0]       owner_q, owner_d;

    logic [N_REQ-1:0] pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             grant_en;

    rr_pick #(.N(N_REQ), .IDX_W(PTR_W)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_oh),
        .idx (pick_idx)
    );

    // Grant is suppressed during reset so the handshake cannot consume an access that gets dropped.
    assign grant_en = !rst && !pause && (|req);
    assign gnt      = grant_en ? pick_oh : '0;

    always_comb begin
        ptr_d       = ptr_q;
        burst_cnt_d = '0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        owner_d[0]  = '0;
        owner_d[1]  = owner_q[0];
        if (grant_en) begin
            ram_en_d    = 1'b1;
            ram_we_d    = we[pick_idx];
            ram_addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
            ram_wdata_d = wdata[pick_idx*DATA_W +: DATA_W];
            owner_d[0]  = we[pick_idx] ? '0 : pick_oh;
            if (lock[pick_idx] && (int'(burst_cnt_q) + 1 < MAX_BURST)) begin
                ptr_d       = pick_idx;
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                ptr_d = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            burst_cnt_q <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            owner_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            owner_q     <= owner_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rvalid    = owner_q[1];
    assign rdata     = ram_rdata;
endmodule
